// File: rtl/pot_scan_sched_if.sv
// A2D converter handshake: the scheduler starts a conversion on a channel,
// and the converter returns a one-cycle completion pulse with the result.
interface pot_scan_sched_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
    modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/pot_scan_sched.sv
// Round-robin scheduler that scans six pots through an A2D and holds the results.
// Optional macro POT_SMOOTH_EN: store a 1/4-step exponential average instead of raw res.
module pot_scan_sched #(
    parameter int TMO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_en,
    pot_scan_sched_if.master a2d,
    output logic [11:0]      LP_pot,
    output logic [11:0]      B1_pot,
    output logic [11:0]      B2_pot,
    output logic [11:0]      B3_pot,
    output logic [11:0]      HP_pot,
    output logic [11:0]      volume,
    output logic             scan_done,
    output logic             tmo_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    state_t      state;
    logic [2:0]  slot;
    logic [7:0]  cnt;
    logic [11:0] res_q;
    logic        store_en;
    logic [11:0] pot_q [6];
    logic [2:0]  slot_nxt;
    logic [11:0] wr_val;

    // Board wiring order: slot index -> A2D channel
    function automatic logic [2:0] slot_ch(input logic [2:0] s);
        case (s)
            3'd0:    slot_ch = 3'd1;
            3'd1:    slot_ch = 3'd0;
            3'd2:    slot_ch = 3'd4;
            3'd3:    slot_ch = 3'd2;
            3'd4:    slot_ch = 3'd3;
            default: slot_ch = 3'd7;
        endcase
    endfunction

    assign slot_nxt = (slot == 3'd5) ? 3'd0 : slot + 3'd1;

`ifdef POT_SMOOTH_EN
    logic [5:0]         vld;
    logic signed [12:0] diff;
    logic signed [12:0] diff_sh;

    // First sample after reset seeds the filter so it does not ramp from zero
    always_comb begin
        diff    = signed'({1'b0, res_q}) - signed'({1'b0, pot_q[slot]});
        diff_sh = diff >>> 2;
        wr_val  = vld[slot] ? pot_q[slot] + diff_sh[11:0] : res_q;
    end
`else
    assign wr_val = res_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot         <= 3'd0;
            cnt          <= 8'd0;
            res_q        <= 12'h000;
            store_en     <= 1'b0;
            a2d.strt_cnv <= 1'b0;
            a2d.chnnl    <= 3'd1;
            scan_done    <= 1'b0;
            tmo_err      <= 1'b0;
            for (int i = 0; i < 6; i++) pot_q[i] <= 12'h000;
`ifdef POT_SMOOTH_EN
            vld          <= 6'b0;
`endif
        end else begin
            a2d.strt_cnv <= 1'b0;
            scan_done    <= 1'b0;
            case (state)
                IDLE: if (seq_en) begin
                    state        <= START;
                    a2d.strt_cnv <= 1'b1;
                    a2d.chnnl    <= slot_ch(slot);
                end
                START: begin
                    state <= WAIT;
                    cnt   <= 8'd0;
                end
                WAIT: begin
                    // A completion on the last allowed cycle wins over the timeout
                    if (a2d.cnv_cmplt) begin
                        res_q     <= a2d.res;
                        store_en  <= 1'b1;
                        state     <= STORE;
                        scan_done <= (slot == 3'd5);
                    end else if (cnt == 8'(TMO_CYC - 1)) begin
                        tmo_err   <= 1'b1;
                        store_en  <= 1'b0;
                        state     <= STORE;
                        scan_done <= (slot == 3'd5);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STORE: begin
                    if (store_en) begin
                        pot_q[slot] <= wr_val;
`ifdef POT_SMOOTH_EN
                        vld[slot]   <= 1'b1;
`endif
                    end
                    slot <= slot_nxt;
                    if (seq_en) begin
                        state        <= START;
                        a2d.strt_cnv <= 1'b1;
                        a2d.chnnl    <= slot_ch(slot_nxt);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign LP_pot = pot_q[0];
    assign B1_pot = pot_q[1];
    assign B2_pot = pot_q[2];
    assign B3_pot = pot_q[3];
    assign HP_pot = pot_q[4];
    assign volume = pot_q[5];
endmodule

// File: doc/pot_scan_sched.md
POT_SCAN_SCHED -- requirements
Module: pot_scan_sched

Interface
REQ-001 SHALL provide parameter TMO_CYC, default 255, meaning wait-state cycles allowed per conversion before timeout abort (range 2..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 seq_en  input  1  level; 1 = run continuous scans, 0 = halt after current conversion.
REQ-005 strt_cnv  output  1  one-cycle pulse to A2D interface starting a conversion.
REQ-006 chnnl  output  3  A2D channel select, valid with strt_cnv and held until conversion ends.
REQ-007 cnv_cmplt  input  1  one-cycle pulse from A2D interface; res valid same cycle.
REQ-008 res  input  12  unsigned conversion result.
REQ-009 LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume  output  12 each  registered pot values.
REQ-010 scan_done  output  1  one-cycle pulse after the last slot of a scan is stored or aborted.
REQ-011 tmo_err  output  1  sticky flag, set on any timeout, cleared only by reset.

Function
REQ-012 Slot order SHALL be fixed: slot0 LP ch1, slot1 B1 ch0, slot2 B2 ch4, slot3 B3 ch2, slot4 HP ch3, slot5 volume ch7.
REQ-013 FSM SHALL have states IDLE, START, WAIT, STORE.
REQ-014 IDLE: if seq_en=1 go START next cycle; else remain.
REQ-015 START: strt_cnv=1 for exactly this cycle, chnnl=slot channel; go WAIT; timeout counter cleared.
REQ-016 WAIT: chnnl held stable; counter increments each cycle; on cnv_cmplt capture res and go STORE.
REQ-017 WAIT: if counter reaches TMO_CYC without cnv_cmplt, set tmo_err, leave slot register unchanged, go STORE with store suppressed.
REQ-018 cnv_cmplt in the same cycle the counter reaches TMO_CYC SHALL count as completion; no timeout.
REQ-019 STORE: write slot register (unless suppressed); slot index advances, wrapping 5->0; if slot was 5 assert scan_done this cycle.
REQ-020 STORE: next state START if seq_en=1, else IDLE; slot index retained in IDLE so resume continues at next slot.
REQ-021 seq_en falling during START/WAIT SHALL NOT abort the conversion; it completes and stores.
REQ-022 cnv_cmplt outside WAIT SHALL be ignored.
REQ-023 Latency: strt_cnv to register update SHALL be (cnv_cmplt cycle)+1; back-to-back slot spacing SHALL be conversion time +2 cycles.
REQ-024 Outputs SHALL be registered; no combinational path from res to pot outputs.

Reset
REQ-025 On rst_n=0, at any time, state SHALL go IDLE, slot index 0, counter 0, strt_cnv=0, chnnl=3'd1, scan_done=0, tmo_err=0, all six pot registers 12'h000.
REQ-026 Reset asserted mid-WAIT SHALL discard the pending conversion; a late cnv_cmplt after release is ignored per REQ-022.

Configuration
REQ-027 Macro POT_SMOOTH_EN: when defined, STORE SHALL write old + ((res - old) >>> 2) using 13-bit signed difference, except the first store per slot after reset, which loads res directly (per-slot valid bit).
REQ-028 Without POT_SMOOTH_EN, STORE SHALL write res directly and no valid bits exist.

Verification
REQ-029 Reset, seq_en=1, ADC model returns 12'hABC on all channels -> after 6 stores all pots = 12'hABC, chnnl sequence 1,0,4,2,3,7, one scan_done per 6 stores.
REQ-030 cnv_cmplt withheld on slot2 (ch4) -> after TMO_CYC wait cycles tmo_err=1, B2_pot unchanged at 12'h000, next strt_cnv on ch2.
REQ-031 cnv_cmplt exactly on the TMO_CYC-th cycle with res=12'h123 -> B2_pot=12'h123, tmo_err stays 0.
REQ-032 seq_en dropped during WAIT of slot3 -> HP not started, B3 stored, FSM IDLE; seq_en=1 again -> next strt_cnv with chnnl=3.
REQ-033 POT_SMOOTH_EN, volume loaded 12'h000 then res=12'h400 -> volume=12'h100 then 12'h1C0 on following scan.
REQ-034 rst_n pulsed low in WAIT of slot4 -> all outputs at reset values immediately; stray cnv_cmplt after release ignored; scan restarts at ch1.
